// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encodings,
// the "PROG" session key and the inactivity timeout width.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        LEN,
        DATA,
        FLUSH,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] KEY_B0 = 8'h50;  // 'P'
    localparam logic [7:0] KEY_B1 = 8'h52;  // 'R'
    localparam logic [7:0] KEY_B2 = 8'h4F;  // 'O'
    localparam logic [7:0] KEY_B3 = 8'h47;  // 'G'

    localparam int TIMEOUT_W = 24;

    function automatic logic [7:0] key_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = KEY_B0;
            2'd1:    b = KEY_B1;
            2'd2:    b = KEY_B2;
            default: b = KEY_B3;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid pulse
// per good frame; frames with a 0 stop bit are silently dropped.
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_reg;
    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             rx_bit;

    assign rx_bit  = sync_reg[1];
    assign data_o  = data_reg;
    assign valid_o = valid_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_reg     <= 2'b11;
            rx_state_reg <= RX_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[0], rx_i};
            rx_state_reg <= rx_state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        data_next     = data_reg;
        valid_next    = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_bit) begin
                    rx_state_next = RX_START;
                    cnt_next      = '0;
                end
            end
            RX_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next      = '0;
                    bit_idx_next  = '0;
                    rx_state_next = rx_bit ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_bit, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next      = '0;
                    rx_state_next = RX_IDLE;
                    if (rx_bit) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: waits for "PROG", a 32-bit little-endian length and
// the image bytes, writes them as memory lines while holding the CPU in reset.
// Optional inactivity timeout is enabled by defining PROG_TIMEOUT_EN.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int BLOCK_SIZE = 128,
    parameter int LINE_AW    = 13
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    prog_rx_i,
    output logic                    wr_en_o,
    output logic [LINE_AW-1:0]      wr_addr_o,
    output logic [BLOCK_SIZE-1:0]   wr_data_o,
    output logic [BLOCK_SIZE/8-1:0] wr_strb_o,
    output logic                    system_reset_no,
    output logic                    prog_mode_led_o
);

    localparam int LANES  = BLOCK_SIZE / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [7:0] rx_byte;
    logic       rx_valid;

    uart_rx_core #(
        .CLKS_PER_BIT(CLK_FREQ / BAUD)
    ) u_rx (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rx_i   (prog_rx_i),
        .data_o (rx_byte),
        .valid_o(rx_valid)
    );

    state_t                state_reg, state_next;
    logic [1:0]            key_idx_reg, key_idx_next;
    logic [31:0]           len_reg, len_next;
    logic [1:0]            len_idx_reg, len_idx_next;
    logic [31:0]           byte_cnt_reg, byte_cnt_next;
    logic [LINE_AW-1:0]    line_addr_reg, line_addr_next;
    logic [BLOCK_SIZE-1:0] line_data_reg, line_data_next;
    logic [LANES-1:0]      line_strb_reg, line_strb_next;
    logic                  wr_en_reg, wr_en_next;
    logic [LINE_AW-1:0]    wr_addr_reg, wr_addr_next;
    logic [BLOCK_SIZE-1:0] wr_data_reg, wr_data_next;
    logic [LANES-1:0]      wr_strb_reg, wr_strb_next;
    logic                  sys_rst_n_reg, sys_rst_n_next;
    logic                  led_reg, led_next;

    assign wr_en_o         = wr_en_reg;
    assign wr_addr_o       = wr_addr_reg;
    assign wr_data_o       = wr_data_reg;
    assign wr_strb_o       = wr_strb_reg;
    assign system_reset_no = sys_rst_n_reg;
    assign prog_mode_led_o = led_reg;

    // Current line buffer with the incoming byte merged into its lane.
    logic [LANE_W-1:0]     lane;
    logic [BLOCK_SIZE-1:0] merged_data;
    logic [LANES-1:0]      merged_strb;
    logic                  line_full;
    logic [31:0]           byte_cnt_inc;
    logic                  last_byte;
    logic [31:0]           len_shifted;

    assign lane         = byte_cnt_reg[LANE_W-1:0];
    assign line_full    = (lane == LANE_W'(LANES - 1));
    assign byte_cnt_inc = byte_cnt_reg + 32'd1;
    assign last_byte    = (byte_cnt_inc == len_reg);
    assign len_shifted  = {rx_byte, len_reg[31:8]};

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic lane_hit;
        assign lane_hit              = (lane == LANE_W'(gi));
        assign merged_data[gi*8 +: 8] = lane_hit ? rx_byte : line_data_reg[gi*8 +: 8];
        assign merged_strb[gi]        = lane_hit | line_strb_reg[gi];
    end

    logic timeout_hit;
`ifdef PROG_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timeout_cnt_reg;
    logic                 waiting;

    assign waiting     = (state_reg == LEN) || (state_reg == DATA);
    assign timeout_hit = waiting && !rx_valid && (&timeout_cnt_reg);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_cnt_reg <= '0;
        end else if (rx_valid || !waiting) begin
            timeout_cnt_reg <= '0;
        end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            key_idx_reg   <= '0;
            len_reg       <= '0;
            len_idx_reg   <= '0;
            byte_cnt_reg  <= '0;
            line_addr_reg <= '0;
            line_data_reg <= '0;
            line_strb_reg <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            wr_strb_reg   <= '0;
            sys_rst_n_reg <= 1'b1;
            led_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            key_idx_reg   <= key_idx_next;
            len_reg       <= len_next;
            len_idx_reg   <= len_idx_next;
            byte_cnt_reg  <= byte_cnt_next;
            line_addr_reg <= line_addr_next;
            line_data_reg <= line_data_next;
            line_strb_reg <= line_strb_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            wr_strb_reg   <= wr_strb_next;
            sys_rst_n_reg <= sys_rst_n_next;
            led_reg       <= led_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        key_idx_next   = key_idx_reg;
        len_next       = len_reg;
        len_idx_next   = len_idx_reg;
        byte_cnt_next  = byte_cnt_reg;
        line_addr_next = line_addr_reg;
        line_data_next = line_data_reg;
        line_strb_next = line_strb_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        wr_strb_next   = wr_strb_reg;
        sys_rst_n_next = sys_rst_n_reg;
        led_next       = led_reg;
        case (state_reg)
            IDLE: begin
                if (rx_valid && rx_byte == KEY_B0) begin
                    state_next   = KEY;
                    key_idx_next = 2'd1;
                end
            end
            KEY: begin
                if (rx_valid) begin
                    if (rx_byte == key_byte(key_idx_reg)) begin
                        key_idx_next = key_idx_reg + 2'd1;
                        if (key_idx_reg == 2'd3) begin
                            state_next     = LEN;
                            len_next       = '0;
                            len_idx_next   = '0;
                            sys_rst_n_next = 1'b0;
                            led_next       = 1'b1;
                        end
                    end else if (rx_byte == KEY_B0) begin
                        key_idx_next = 2'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            LEN: begin
                if (rx_valid) begin
                    // Bytes shift in from the top so the first one ends up in bits 7:0.
                    len_next     = len_shifted;
                    len_idx_next = len_idx_reg + 2'd1;
                    if (len_idx_reg == 2'd3) begin
                        byte_cnt_next  = '0;
                        line_addr_next = '0;
                        line_data_next = '0;
                        line_strb_next = '0;
                        state_next     = (len_shifted == 32'd0) ? DONE : DATA;
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    byte_cnt_next  = byte_cnt_inc;
                    line_data_next = merged_data;
                    line_strb_next = merged_strb;
                    if (line_full || last_byte) begin
                        wr_en_next     = 1'b1;
                        wr_addr_next   = line_addr_reg;
                        wr_data_next   = merged_data;
                        wr_strb_next   = merged_strb;
                        line_data_next = '0;
                        line_strb_next = '0;
                        if (line_full) begin
                            line_addr_next = line_addr_reg + 1'b1;
                        end
                    end
                    if (last_byte) begin
                        state_next = line_full ? DONE : FLUSH;
                    end
                end
            end
            FLUSH, DONE: begin
                state_next     = (state_reg == FLUSH) ? DONE : IDLE;
                sys_rst_n_next = 1'b1;
                led_next       = 1'b0;
            end
            default: state_next = IDLE;
        endcase

        // A stalled sender still gets whatever was already buffered.
        if (timeout_hit) begin
            if (state_reg == DATA && |line_strb_reg) begin
                wr_en_next     = 1'b1;
                wr_addr_next   = line_addr_reg;
                wr_data_next   = line_data_reg;
                wr_strb_next   = line_strb_reg;
                line_data_next = '0;
                line_strb_next = '0;
                state_next     = FLUSH;
            end else begin
                state_next = DONE;
            end
        end
    end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk_i frequency in Hz.
REQ-002 The module SHALL have parameter BAUD, default 115_200, meaning the serial bit rate.
REQ-003 The module SHALL have parameter BLOCK_SIZE, default 128, meaning the memory line width in bits.
REQ-004 The module SHALL have parameter LINE_AW, default 13, meaning the line-address width (8192 lines).
REQ-005 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The module SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The module SHALL have port prog_rx_i, input, 1 bit: serial programming line, idle high, asynchronous to clk_i.
REQ-008 The module SHALL have port wr_en_o, output, 1 bit: single-cycle line-write strobe.
REQ-009 The module SHALL have port wr_addr_o, output, LINE_AW bits: line address of the write.
REQ-010 The module SHALL have port wr_data_o, output, BLOCK_SIZE bits: line write data.
REQ-011 The module SHALL have port wr_strb_o, output, BLOCK_SIZE/8 bits: byte enables of the write.
REQ-012 The module SHALL have port system_reset_no, output, 1 bit: low holds the CPU in reset.
REQ-013 The module SHALL have port prog_mode_led_o, output, 1 bit: high while a programming session is active.

Function
REQ-014 prog_rx_i SHALL pass through a 2-flop synchronizer; the receiver SHALL be 8N1, sample at mid-bit (CLK_FREQ/BAUD clocks per bit) and drop a frame whose stop bit is 0.
REQ-015 States: IDLE, KEY, LEN, DATA, FLUSH, DONE; the state machine SHALL consume exactly one received byte per rx-valid pulse.
REQ-016 IDLE/KEY: the FSM SHALL match the 4-byte key 0x50,0x52,0x4F,0x47 ("PROG"); a mismatching byte SHALL restart matching, and a mismatching 0x50 SHALL count as key byte 1.
REQ-017 On a full key match the FSM SHALL enter LEN, and system_reset_no SHALL drop and prog_mode_led_o SHALL rise in the next cycle.
REQ-018 LEN: the FSM SHALL take 4 bytes little-endian as the byte count N (32 bit); N==0 SHALL go directly to DONE with no write.
REQ-019 DATA: the FSM SHALL pack byte k of the stream into line k/16 at byte lane k%16 (lane 0 = bits 7:0).
REQ-020 After the 16th byte of a line, wr_en_o SHALL pulse for one cycle with wr_strb_o all ones, and the line address SHALL then increment.
REQ-021 When byte N is accepted and N%16!=0, the FSM SHALL pass through FLUSH and write the partial line with strobes set only for the received lanes; unreceived lanes SHALL be zero.
REQ-022 The line address SHALL wrap modulo 2^LINE_AW; there SHALL be no error on overflow.
REQ-023 DONE: system_reset_no SHALL go high and prog_mode_led_o low one cycle after the final write, then the FSM SHALL return to IDLE.
REQ-024 Write latency SHALL be exactly 1 clock from the rx-valid pulse of the completing byte to wr_en_o.
REQ-025 Key bytes received outside IDLE/KEY SHALL be treated as data.

Reset
REQ-026 rst_i high SHALL force immediately: FSM IDLE, counters 0, wr_en_o 0, wr_addr_o 0, wr_data_o 0, wr_strb_o 0, system_reset_no 1, prog_mode_led_o 0.
REQ-027 rst_i asserted mid-session SHALL abort the session, discard any buffered partial line, and release the CPU reset.

Configuration
REQ-028 With PROG_TIMEOUT_EN defined, 2^24 clocks without an rx-valid pulse in LEN or DATA SHALL flush any partial line and then proceed as DONE.
REQ-029 Without PROG_TIMEOUT_EN, the FSM SHALL wait indefinitely, and the timeout counter SHALL not be synthesized.

Structure
REQ-030 A shared package loader_pkg SHALL hold the state enum, the key byte constants and the timeout width.
REQ-031 The serial receiver SHALL be a sub-module uart_rx_core (synchronizer, baud counter, byte plus valid pulse).

Verification
REQ-032 Test: "PROG", N=16, bytes 0x00..0x0F -> one write, addr 0, data 0x0F0E..0100, strb 0xFFFF; reset_no low→high.
REQ-033 Test: "PROG", N=20 -> writes at addr 0 (strb 0xFFFF) and addr 1 (strb 0x000F, upper lanes 0).
REQ-034 Test: "PPROG", N=0 -> key accepted, no wr_en_o, system_reset_no low for about 4 byte times then high.
REQ-035 Test: rst_i pulse after 10 of 16 data bytes -> no write, system_reset_no 1, FSM IDLE.
REQ-036 Test: with PROG_TIMEOUT_EN, N=32, stop after 5 bytes -> after 2^24 clocks, write addr 0 with strb 0x001F; session ends.
REQ-037 Test: frame with stop bit 0 inside the key -> byte dropped, key match not completed.
